// File: rtl/apuf_eval_ctrl.sv
// Evaluation sequencer for a 32-bit arbiter PUF: captures a challenge, runs N_EVAL
// reset/race/sample/recover cycles and majority-votes the synchronised arbiter outputs.
module apuf_eval_ctrl #(
    parameter  int CW          = 32,
    parameter  int N_EVAL      = 5,
    parameter  int RST_CYC     = 2,
    parameter  int SETTLE_CYC  = 4,
    parameter  int RECOVER_CYC = 4,
    localparam int CNT_W       = $clog2(N_EVAL + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    output logic             Ready,
    input  logic [CW-1:0]    Challenge_in,
    output logic [CW-1:0]    Challenge,
    output logic             Pulse,
    output logic             Arb_reset,
    input  logic             Result,
    output logic             Resp_valid,
    input  logic             Resp_ready,
    output logic             Resp_bit,
    output logic [CNT_W-1:0] Ones_count,
    output logic             Unstable
);

    localparam int SAMPLE_CYC = 2;
    localparam int MAX_A      = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int MAX_B      = (RECOVER_CYC > SAMPLE_CYC) ? RECOVER_CYC : SAMPLE_CYC;
    localparam int MAX_CYC    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int PH_W       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    if ((N_EVAL < 1) || ((N_EVAL % 2) == 0)) begin : g_bad_n_eval
        $error("apuf_eval_ctrl: N_EVAL must be odd and >= 1");
    end
    if ((RST_CYC < 1) || (SETTLE_CYC < 1) || (RECOVER_CYC < 1)) begin : g_bad_cyc
        $error("apuf_eval_ctrl: RST_CYC, SETTLE_CYC and RECOVER_CYC must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB_RST = 3'd1,
        S_FIRE    = 3'd2,
        S_SAMPLE  = 3'd3,
        S_RECOVER = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state_r;
    logic [PH_W-1:0]   phase_r;
    logic [CNT_W-1:0]  eval_r;
    logic [CNT_W-1:0]  ones_r;
    logic              sync1_r;
    logic              sync2_r;

    function automatic logic majority(input logic [CNT_W-1:0] ones);
        return (ones > CNT_W'(N_EVAL / 2));
    endfunction

    function automatic logic disagree(input logic [CNT_W-1:0] ones);
        return (ones != CNT_W'(0)) && (ones != CNT_W'(N_EVAL));
    endfunction

    assign Ready = (state_r == S_IDLE);

    // Two-flop synchroniser for the asynchronous arbiter output
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= Result;
            sync2_r <= sync1_r;
        end
    end

    // Evaluation FSM; outputs are updated on the same edge as the state they belong to
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= S_IDLE;
            phase_r    <= PH_W'(0);
            eval_r     <= CNT_W'(0);
            ones_r     <= CNT_W'(0);
            Challenge  <= CW'(0);
            Pulse      <= 1'b0;
            Arb_reset  <= 1'b1;
            Resp_valid <= 1'b0;
            Resp_bit   <= 1'b0;
            Ones_count <= CNT_W'(0);
            Unstable   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    Pulse     <= 1'b0;
                    Arb_reset <= 1'b1;
                    phase_r   <= PH_W'(0);
                    if (Start) begin
                        Challenge  <= Challenge_in;
                        eval_r     <= CNT_W'(0);
                        ones_r     <= CNT_W'(0);
                        Resp_bit   <= 1'b0;
                        Ones_count <= CNT_W'(0);
                        Unstable   <= 1'b0;
                        state_r    <= S_ARB_RST;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end

                S_ARB_RST: begin
                    if (phase_r == PH_W'(RST_CYC - 1)) begin
                        phase_r   <= PH_W'(0);
                        Arb_reset <= 1'b0;
                        Pulse     <= 1'b1;
                        state_r   <= S_FIRE;
                    end else begin
                        phase_r <= phase_r + PH_W'(1);
                    end
                end

                S_FIRE: begin
                    if (phase_r == PH_W'(SETTLE_CYC - 1)) begin
                        phase_r <= PH_W'(0);
                        state_r <= S_SAMPLE;
                    end else begin
                        phase_r <= phase_r + PH_W'(1);
                    end
                end

                // The two sample cycles give the synchroniser time to settle after the race
                S_SAMPLE: begin
                    if (phase_r == PH_W'(SAMPLE_CYC - 1)) begin
                        phase_r <= PH_W'(0);
                        ones_r  <= ones_r + CNT_W'(sync2_r);
                        Pulse   <= 1'b0;
                        state_r <= S_RECOVER;
                    end else begin
                        phase_r <= phase_r + PH_W'(1);
                    end
                end

                S_RECOVER: begin
                    if (phase_r == PH_W'(RECOVER_CYC - 1)) begin
                        phase_r   <= PH_W'(0);
                        eval_r    <= eval_r + CNT_W'(1);
                        Arb_reset <= 1'b1;
                        if (eval_r == CNT_W'(N_EVAL - 1)) begin
                            state_r <= S_DONE;
                        end else begin
                            state_r <= S_ARB_RST;
                        end
                    end else begin
                        phase_r <= phase_r + PH_W'(1);
                    end
                end

                // First DONE cycle publishes the vote; later cycles wait for the consumer
                S_DONE: begin
                    Arb_reset <= 1'b1;
                    Pulse     <= 1'b0;
                    if (!Resp_valid) begin
                        Resp_valid <= 1'b1;
                        Resp_bit   <= majority(ones_r);
                        Ones_count <= ones_r;
                        Unstable   <= disagree(ones_r);
                    end else if (Resp_ready) begin
                        Resp_valid <= 1'b0;
                        state_r    <= S_IDLE;
                    end else begin
                        Resp_valid <= 1'b1;
                    end
                end

                default: begin
                    state_r    <= S_IDLE;
                    phase_r    <= PH_W'(0);
                    Pulse      <= 1'b0;
                    Arb_reset  <= 1'b1;
                    Resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
